// File: rtl/text_line_renderer.sv
// Single-line text overlay: maps the current pixel onto a character cell,
// looks the character up in a small buffer, sends ascii/row to an external
// font ROM and turns the returned glyph row into a per-pixel lit flag.
// Two-stage pipeline, one pixel per clock, with an optional blink mask.
module text_line_renderer #(
   parameter logic [9:0] X0         = 10'd100,
   parameter logic [9:0] Y0         = 10'd200,
   parameter int         NCHARS     = 16,
   parameter int         SCALE_LOG2 = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] pix_x,
   input  logic [9:0] pix_y,
   input  logic       video_on,
   input  logic       frame_tick,
   input  logic       blink_en,
   input  logic       wr_en,
   input  logic [4:0] wr_addr,
   input  logic [7:0] wr_char,
   output logic [7:0] font_ascii,
   output logic [3:0] font_row,
   input  logic [7:0] font_bits,
   output logic       text_on,
   output logic       video_on_d
);

   localparam int          IDX_W   = $clog2(NCHARS);
   localparam logic [10:0] BOX_W11 = 11'((NCHARS * 8) << SCALE_LOG2);
   localparam logic [10:0] BOX_H11 = 11'(16 << SCALE_LOG2);
   localparam logic [7:0]  SPACE   = 8'd32;

   logic [7:0]       r_buf [NCHARS];
   logic [7:0]       r_font_ascii;
   logic [3:0]       r_font_row;
   logic [2:0]       r_col_d;
   logic             r_in_box_d;
   logic             r_video_d1;
   logic             r_text_on;
   logic             r_video_d2;
   logic [4:0]       r_frame_cnt;
   logic             r_phase;

   logic [10:0]      w_dx;
   logic [10:0]      w_dy;
   logic             w_in_box;
   logic [IDX_W-1:0] w_idx;
   logic [2:0]       w_col;
   logic [3:0]       w_row;
   logic [IDX_W-1:0] w_wr_slot;
   logic [2:0]       w_bit_sel;
   logic             w_blank;
   logic             w_unused_ok;

   // Stage-1 geometry. Subtraction is 11 bits wide so a pixel left of / above
   // the box produces a huge dx/dy; the explicit >= test keeps it out anyway.
   assign w_dx      = {1'b0, pix_x} - {1'b0, X0};
   assign w_dy      = {1'b0, pix_y} - {1'b0, Y0};
   assign w_in_box  = (pix_x >= X0) && (w_dx < BOX_W11) &&
                      (pix_y >= Y0) && (w_dy < BOX_H11);
   assign w_idx     = w_dx[IDX_W + 3 + SCALE_LOG2 - 1 : 3 + SCALE_LOG2];
   assign w_col     = w_dx[SCALE_LOG2 + 2 : SCALE_LOG2];
   assign w_row     = w_dy[SCALE_LOG2 + 3 : SCALE_LOG2];
   assign w_wr_slot = wr_addr[IDX_W-1:0];
   assign w_bit_sel = 3'd7 - r_col_d;
   assign w_blank   = blink_en & r_phase;
   // Upper address bits are intentionally ignored for small buffers.
   assign w_unused_ok = &{1'b0, wr_addr};

   // Character buffer: reset fills with spaces; a write and a read of the same
   // slot in one cycle returns the old contents (plain register semantics).
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NCHARS; i++) r_buf[i] <= SPACE;
      end else if (wr_en) begin
         r_buf[w_wr_slot] <= wr_char;
      end
   end

   // Stage 1: font ROM address plus alignment registers for stage 2.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_font_ascii <= SPACE;
         r_font_row   <= 4'd0;
         r_col_d      <= 3'd0;
         r_in_box_d   <= 1'b0;
         r_video_d1   <= 1'b0;
      end else begin
         r_font_ascii <= w_in_box ? r_buf[w_idx] : SPACE;
         r_font_row   <= w_in_box ? w_row : 4'd0;
         r_col_d      <= w_col;
         r_in_box_d   <= w_in_box;
         r_video_d1   <= video_on;
      end
   end

   // Stage 2: pick the glyph bit (MSB = leftmost) and apply the blink mask.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_text_on  <= 1'b0;
         r_video_d2 <= 1'b0;
      end else begin
         r_text_on  <= r_in_box_d & r_video_d1 & font_bits[w_bit_sel] & ~w_blank;
         r_video_d2 <= r_video_d1;
      end
   end

   // Blink timebase: phase flips every 32 frames; it keeps running even when
   // blinking is disabled so re-enabling stays in step with the frame count.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_frame_cnt <= 5'd0;
         r_phase     <= 1'b0;
      end else if (frame_tick) begin
         r_frame_cnt <= r_frame_cnt + 5'd1;
         if (r_frame_cnt == 5'd31) r_phase <= ~r_phase;
      end
   end

   assign font_ascii = r_font_ascii;
   assign font_row   = r_font_row;
   assign text_on    = r_text_on;
   assign video_on_d = r_video_d2;

endmodule

// File: tb/tb_text_line_renderer.sv
// Bench for text_line_renderer with default parameters. Models the font ROM,
// keeps a behavioural model of the buffer/blink state, and checks the
// stage-1 (ascii,row) and stage-2 (text_on,video_on_d) outputs every cycle.
module tb_text_line_renderer;

   localparam int X0  = 100;
   localparam int Y0  = 200;
   localparam int NCH = 16;
   localparam int SC  = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] pix_x = '0;
   logic [9:0] pix_y = '0;
   logic       video_on = 1'b0;
   logic       frame_tick = 1'b0;
   logic       blink_en = 1'b0;
   logic       wr_en = 1'b0;
   logic [4:0] wr_addr = '0;
   logic [7:0] wr_char = '0;
   logic [7:0] font_ascii;
   logic [3:0] font_row;
   logic [7:0] font_bits;
   logic       text_on;
   logic       video_on_d;

   int checks = 0;
   int errors = 0;

   logic [11:0] exp_s1_q[$];
   logic [1:0]  exp_s2_q[$];

   int   m_buf [NCH];
   int   m_cnt;
   bit   m_phase;
   bit   m_pend_lit;
   bit   m_pend_von;
   bit   g_ben;

   text_line_renderer dut (
      .clk(clk), .rst(rst), .pix_x(pix_x), .pix_y(pix_y), .video_on(video_on),
      .frame_tick(frame_tick), .blink_en(blink_en), .wr_en(wr_en),
      .wr_addr(wr_addr), .wr_char(wr_char), .font_ascii(font_ascii),
      .font_row(font_row), .font_bits(font_bits), .text_on(text_on),
      .video_on_d(video_on_d)
   );

   // clock
   always #5 clk = ~clk;

   // Font ROM model: 'A' has a real glyph, other printable codes get a
   // synthetic pattern, space and everything unmapped return 0.
   function automatic logic [7:0] font_fn(input int a, input int r);
      int t;
      if (a == 65) begin
         case (r)
            0: return 8'h18;  1: return 8'h3C;  2: return 8'h66;  3: return 8'h66;
            4: return 8'hC3;  5: return 8'hC3;  6: return 8'hFF;  7: return 8'hFF;
            14, 15: return 8'h00;
            default: return 8'hC3;
         endcase
      end
      if (a > 32 && a < 127) begin
         t = a * 37 + r * 11;
         return t[7:0];
      end
      return 8'h00;
   endfunction

   assign font_bits = font_fn(int'(font_ascii), int'(font_row));

   task automatic model_reset();
      for (int i = 0; i < NCH; i++) m_buf[i] = 32;
      m_cnt = 0;
      m_phase = 0;
      m_pend_lit = 0;
      m_pend_von = 0;
   endtask

   // One clock of stimulus; pushes the expected results it implies.
   task automatic drive(input int x, input int y, input bit von, input bit tick,
                        input bit ben, input bit we, input int wa, input int wc,
                        input bit r);
      int idx, col, row, a;
      bit inb, lit;
      logic [7:0] g;
      @(negedge clk);
      pix_x = x[9:0]; pix_y = y[9:0]; video_on = von; frame_tick = tick;
      blink_en = ben; wr_en = we; wr_addr = wa[4:0]; wr_char = wc[7:0]; rst = r;
      if (r) begin
         exp_s2_q.push_back(2'b00);
         exp_s1_q.push_back({8'd32, 4'd0});
         model_reset();
      end else begin
         // previous pixel resolves at this edge, blanked by the phase reached so far
         exp_s2_q.push_back({m_pend_lit & !(ben & m_phase), m_pend_von});
         inb = (x >= X0) && (x < X0 + NCH * 8 * SC) && (y >= Y0) && (y < Y0 + 16 * SC);
         if (inb) begin
            idx = (x - X0) / (8 * SC);
            col = ((x - X0) / SC) % 8;
            row = ((y - Y0) / SC) % 16;
            a   = m_buf[idx];
         end else begin
            idx = 0; col = 0; row = 0; a = 32;
         end
         g = font_fn(a, row);
         lit = inb && von && g[7 - col];
         exp_s1_q.push_back({a[7:0], row[3:0]});
         m_pend_lit = lit;
         m_pend_von = von;
         if (tick) begin
            m_cnt = m_cnt + 1;
            if (m_cnt == 32) begin
               m_cnt = 0;
               m_phase = !m_phase;
            end
         end
         if (we) m_buf[wa % NCH] = wc;
      end
   endtask

   task automatic pix(input int x, input int y);
      drive(x, y, 1, 0, g_ben, 0, 0, 0, 0);
   endtask

   task automatic tick_pix(input int x, input int y);
      drive(x, y, 1, 1, g_ben, 0, 0, 0, 0);
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, g_ben, 0, 0, 0, 0);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // scoreboard monitor: sample 1ns after each rising edge
   always @(posedge clk) begin
      logic [11:0] e1;
      logic [1:0]  e2;
      #1;
      if (exp_s1_q.size() > 0) begin
         e1 = exp_s1_q.pop_front();
         chk("font_ascii", int'(font_ascii), int'(e1[11:4]));
         chk("font_row", int'(font_row), int'(e1[3:0]));
      end
      if (exp_s2_q.size() > 0) begin
         e2 = exp_s2_q.pop_front();
         chk("text_on", int'(text_on), int'(e2[1]));
         chk("video_on_d", int'(video_on_d), int'(e2[0]));
      end
   end

   initial begin
      int x, y, wc, sel;
      bit von, tk, we, r;
      g_ben = 0;
      model_reset();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
      idle();

      // basic lookup: 'A' in slot 0, col 0 dark, col 3 lit
      drive(0, 0, 0, 0, 0, 1, 0, 65, 0);
      pix(100, 200);
      pix(106, 200);
      idle(); idle();

      // read-during-write on slot 3, then the following pixel sees the new code
      drive(148, 200, 1, 0, 0, 1, 3, 86, 0);
      pix(148, 200);
      idle(); idle();

      // fill every slot with 'A' and probe the box edges
      for (int i = 0; i < NCH; i++) drive(0, 0, 0, 0, 0, 1, i, 65, 0);
      pix(99, 200); pix(356, 200); pix(100, 199); pix(100, 232);
      pix(355, 231); pix(355, 200); pix(100, 231); pix(106, 200);
      idle(); idle();

      // blink: 32 frames set the phase, 32 more clear it
      g_ben = 1;
      for (int i = 0; i < 32; i++) tick_pix(106, 200);
      for (int i = 0; i < 4; i++) pix(106, 200);
      g_ben = 0;
      for (int i = 0; i < 3; i++) pix(106, 200);
      g_ben = 1;
      for (int i = 0; i < 3; i++) pix(106, 200);
      for (int i = 0; i < 32; i++) tick_pix(106, 200);
      for (int i = 0; i < 4; i++) pix(106, 200);
      g_ben = 0;

      // reset in the middle of a lit run
      pix(106, 200); pix(107, 200);
      drive(106, 200, 1, 0, 0, 1, 2, 65, 1);
      for (int i = 0; i < NCH; i++) pix(106 + 16 * i, 200);
      idle(); pix(106, 202); idle();

      // random traffic
      for (int n = 0; n < 2500; n++) begin
         x   = $urandom_range(90, 370);
         y   = $urandom_range(190, 240);
         von = ($urandom_range(0, 7) != 0);
         tk  = ($urandom_range(0, 2) == 0);
         we  = ($urandom_range(0, 3) == 0);
         sel = $urandom_range(0, 3);
         wc  = (sel == 0) ? 65 : (sel == 1) ? 200 : $urandom_range(32, 126);
         r   = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 49) == 0) g_ben = !g_ben;
         drive(x, y, von, tk, g_ben, we, $urandom_range(0, 31), wc, r);
      end

      for (int i = 0; i < 4; i++) idle();
      @(posedge clk);
      #2;
      if (exp_s1_q.size() != 0 || exp_s2_q.size() != 0)
         chk("queue_drain", exp_s1_q.size() + exp_s2_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/text_line_renderer.md
TEXT_LINE_RENDERER -- requirements
Module: text_line_renderer

Interface
REQ-001 Parameters SHALL be: X0, default 10'd100, left pixel column of the text box; Y0, default 10'd200, top pixel row; NCHARS, default 16, characters per line (power of two, 2..32); SCALE_LOG2, default 1, glyph magnification 2^SCALE_LOG2, legal values 0..2.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 Ports SHALL be:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- pix_x  in  10  current pixel column
- pix_y  in  10  current pixel row
- video_on  in  1  active-video qualifier
- frame_tick  in  1  one-cycle pulse per frame
- blink_en  in  1  enables blinking
- wr_en  in  1  character-buffer write strobe
- wr_addr  in  5  buffer slot, only bits below log2(NCHARS) are used
- wr_char  in  8  ASCII code to store
- font_ascii  out  8  registered ASCII code to the font ROM
- font_row  out  4  registered glyph row to the font ROM
- font_bits  in  8  combinational ROM row response, MSB is the leftmost pixel
- text_on  out  1  registered pixel-lit flag
- video_on_d  out  1  video_on delayed to align with text_on

Function
REQ-004 A character buffer of NCHARS x 8-bit registers SHALL be written on the rising edge when wr_en=1: buf[wr_addr] <= wr_char.
REQ-005 The text box SHALL be defined as:
- pix_x in [X0, X0 + NCHARS*8*2^S)
- pix_y in [Y0, Y0 + 16*2^S)
- S = SCALE_LOG2; both bounds are inclusive on the left and exclusive on the right.
REQ-006 Stage 1 SHALL compute the following with 11-bit unsigned arithmetic, with no wrap into the box for pix_x < X0:
- dx = pix_x - X0 and dy = pix_y - Y0
- idx = dx >> (3+S)
- col = (dx >> S)[2:0]
- row = (dy >> S)[3:0]
- in_box
REQ-007 At the end of stage 1 the block SHALL register:
- font_ascii <= buf[idx] when in_box, else 8'd32
- font_row <= row when in_box, else 0
- col, in_box and video_on into pipeline registers
REQ-008 Stage 2 SHALL register text_on <= in_box_d & video_on_d1 & font_bits[7-col_d] & ~blank.
REQ-009 Stage 2 SHALL register video_on_d <= video_on_d1.
REQ-010 Latency SHALL be exactly 2 clocks from pix_x/pix_y/video_on to text_on/video_on_d, with one result per clock and no stalls.
REQ-011 Read-during-write to the same slot SHALL make font_ascii carry the old value in that cycle and the new value from the next cycle onward.
REQ-012 Blink logic SHALL consist of a 5-bit frame counter and a phase bit:
- the counter increments on each frame_tick
- on the 31->0 wrap, phase toggles
- blank = blink_en & phase
REQ-013 frame_tick and wr_en coincident with pixel traffic SHALL NOT disturb the pipeline.
REQ-014 When blink_en=0, the counter SHALL keep running and blank SHALL be 0.
REQ-015 For any ascii value that the font ROM does not map, font_bits=0 and text_on=0 SHALL result naturally; the block SHALL NOT filter codes.

Reset
REQ-016 When rst=1 at a rising edge, the block SHALL set:
- all buffer slots to 8'd32
- font_ascii=8'd32 and font_row=0
- all pipeline registers, text_on and video_on_d to 0
- frame counter=0 and phase=0
REQ-017 Reset asserted mid-line SHALL zero text_on on the next edge and hold it at 0 while rst=1.
REQ-018 Writes presented while rst=1 SHALL be ignored.
REQ-019 The first valid text_on after rst deasserts SHALL appear 2 clocks after the first sampled pixel.

Verification
All scenarios use defaults (X0=100, Y0=200, S=1, NCHARS=16) with the bench modelling the font ROM, where 'A' row 0 = 00011000.
REQ-020 Write buf[0]=65, then drive pix=(100,200) with video_on=1:
- font_ascii=65 and font_row=0 after 1 clock
- text_on=0 after 2 clocks (col 0)
- with pix_x=106 (col 3), text_on=1 after 2 clocks
REQ-021 Boundaries, with every buffer slot set to 65 and video_on=1:
- pix_x=99, 356 or pix_y=199, 232: text_on=0 and font_ascii=32
- pix_x=355, pix_y=231 (idx 15, row 15): font_ascii=65, font_row=15
REQ-022 Write buf[3]=86 in the same cycle that pix_x=148, pix_y=200 (idx 3) is presented:
- font_ascii shows the old value 32 after 1 clock
- the next pixel at idx 3 shows 86
REQ-023 With blink_en=1, issue 32 frame_tick pulses:
- phase=1 and text_on is forced to 0 on lit pixels
- after 32 more pulses, text_on returns to lit
- blink_en=0 restores text_on immediately, at the 2-clock latency
REQ-024 Assert rst for 1 cycle during a lit run:
- text_on=0 on the next edge
- the buffer reads 32 for every slot afterward
- video_on_d tracks video_on with a 2-clock delay after release
